// File: rtl/uart_tx_fifo_if.sv
// Producer/uarttx-facing signal bundle for uart_tx_fifo, with the drain FSM
// state exposed for observation.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          tx_mon;
  logic          donetx;
  logic          newd;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;
  logic [1:0]    state;

  // Handshake: newd stays high with tx_data stable until the uarttx pulls
  // tx_mon low (start bit); the byte is finished on a rising edge of donetx.
  // A write is taken on any cycle with wr_en=1 and full=0; there is no ready.
  modport master (
    output wr_en, wr_data, flush, tx_mon, donetx,
    input  newd, tx_data, full, empty, count, overflow, busy, state
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_mon, donetx,
    output newd, tx_data, full, empty, count, overflow, busy, state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a slow uarttx: queues producer writes and drains them
// one at a time through a newd / tx_mon / donetx handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          gap_q, gap_d;
  logic          newd_q, newd_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          tx_mon_s1_q, tx_mon_s2_q;
  logic          donetx_s1_q, donetx_s2_q, donetx_prev_q;

  logic full, empty, wr_acc, pop;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full && !bus.flush;
  assign pop    = (state_q == S_IDLE) && !empty;

  // Flush wins over the pointer/count update but a same-cycle pop still loads tx_data.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = bus.wr_en && full;
    if (pop) begin
      tx_data_d = mem_q[rptr_q];
    end
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (pop)    rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!tx_mon_s2_q) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (donetx_s2_q && !donetx_prev_q) begin
          state_d = S_GAP;
          gap_d   = 1'b0;
        end
      end
      S_GAP: begin
        // Two cycles here keep a fresh newd away from a still-high donetx.
        if (gap_q) state_d = S_IDLE;
        else       gap_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    newd_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      gap_q         <= 1'b0;
      newd_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      overflow_q    <= 1'b0;
      tx_mon_s1_q   <= 1'b1;
      tx_mon_s2_q   <= 1'b1;
      donetx_s1_q   <= 1'b0;
      donetx_s2_q   <= 1'b0;
      donetx_prev_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      gap_q         <= gap_d;
      newd_q        <= newd_d;
      tx_data_q     <= tx_data_d;
      overflow_q    <= overflow_d;
      tx_mon_s1_q   <= bus.tx_mon;
      tx_mon_s2_q   <= tx_mon_s1_q;
      donetx_s1_q   <= bus.donetx;
      donetx_s2_q   <= donetx_s1_q;
      donetx_prev_q <= donetx_s2_q;
    end
  end

  assign bus.newd     = newd_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.state    = state_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  producer write strobe, one byte per cycle.
REQ-006 wr_data  in  8  byte to queue.
REQ-007 flush  in  1  synchronous clear of all queued bytes.
REQ-008 tx_mon  in  1  serial line driven by the downstream uarttx; low indicates the start bit.
REQ-009 donetx  in  1  uarttx completion flag, slow-clock domain.
REQ-010 newd  out  1  new-data request to uarttx.
REQ-011 tx_data  out  8  byte presented to uarttx.
REQ-012 full  out  1  count equals DEPTH.
REQ-013 empty  out  1  count equals 0.
REQ-014 count  out  AW+1  number of bytes queued, 0..DEPTH.
REQ-015 overflow  out  1  one-cycle pulse on a rejected write.
REQ-016 busy  out  1  drain FSM is not in IDLE.

Function
REQ-017 A write with wr_en=1 and full=0 SHALL store wr_data at wptr, increment wptr mod DEPTH, and increment count.
REQ-018 A write with full=1 SHALL be dropped and pulse overflow for one cycle, even if a pop occurs in the same cycle; full is the pre-edge value.
REQ-019 A write and a pop in the same cycle with full=0 and empty=0 SHALL leave count unchanged and advance both pointers.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-021 tx_mon and donetx SHALL each pass through a 2-flop synchronizer before use.
REQ-022 The drain FSM SHALL have states IDLE, ISSUE, WAIT_DONE and GAP.
REQ-023 IDLE: if empty=0, pop the head into the tx_data register, increment rptr, decrement count, and go to ISSUE; otherwise stay in IDLE.
REQ-024 ISSUE: newd=1 and tx_data held stable; on synchronized tx_mon=0, newd=0 in the next cycle and go to WAIT_DONE.
REQ-025 WAIT_DONE: newd=0; on a synchronized donetx 0->1 edge, go to GAP.
REQ-026 GAP: stay for 2 clk cycles, then return to IDLE, so that newd can never be seen high by uarttx while donetx is still asserted.
REQ-027 newd SHALL be registered and asserted only in ISSUE.
REQ-028 tx_data SHALL change only on the pop in IDLE.
REQ-029 Latency: newd SHALL rise 1 cycle after IDLE sees empty=0, giving 2 cycles from the first write into an empty FIFO.
REQ-030 flush=1 SHALL clear wptr, rptr and count in the next cycle and discard a same-cycle write.
REQ-031 flush SHALL NOT abort a byte already in ISSUE or WAIT_DONE; that byte completes normally.
REQ-032 flush and a pop in the same cycle: the pop SHALL complete and count SHALL end at 0.
REQ-033 busy SHALL equal (state != IDLE).

Reset
REQ-034 On rst=1, asynchronously and independent of clk: state=IDLE, wptr=rptr=0, count=0, newd=0, tx_data=8'h00, overflow=0, empty=1, full=0, synchronizer flops=1 for tx_mon and 0 for donetx.
REQ-035 A mid-operation reset SHALL abandon the in-flight byte and the queued contents; no newd SHALL appear until a new write after rst deasserts.
REQ-036 FIFO storage need not be reset; its contents SHALL be unobservable after reset.

Verification
REQ-037 Single byte: write 8'hA5 into an empty FIFO -> newd rises 2 cycles later with tx_data=8'hA5; a bus-functional uarttx model drives tx_mon low -> newd falls; donetx pulse -> GAP -> IDLE, empty=1.
REQ-038 Ordering: write 8'h01..8'h05 back-to-back -> uarttx model receives 01,02,03,04,05 in order, exactly one newd window per byte, no duplicates.
REQ-039 Full/overflow: fill DEPTH bytes with the model stalled -> full=1, count=16; 17th write -> overflow pulse, count stays 16; draining all bytes returns the original 16 with pointer wrap verified.
REQ-040 Simultaneous: write during the IDLE pop cycle at count=3 -> count stays 3; write while full during a pop -> dropped, overflow=1.
REQ-041 Flush: queue 4 bytes, flush while byte 1 is in WAIT_DONE -> byte 1 completes, no further newd, count=0, empty=1.
REQ-042 Reset: assert rst asynchronously between clk edges while in ISSUE -> newd=0 immediately, count=0; the next write after release sends only the new byte.
